vedic_pp_combine: RTL
=====================

VEDIC_PP_COMBINE -- requirements
Module: vedic_pp_combine

Interface
REQ-001 Parameter: H, default 4, half-operand width; operands are 2H bits wide, partial products 2H bits wide, and the product is 4H bits wide.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset; synchronous to clk, active-high.
REQ-004 Port: in_valid  input  1  partial-product set valid.
REQ-005 Port: in_ready  output  1  block accepts the set this cycle.
REQ-006 Port: pp_ll  input  2H  a_lo*b_lo.
REQ-007 Port: pp_lh  input  2H  a_lo*b_hi.
REQ-008 Port: pp_hl  input  2H  a_hi*b_lo.
REQ-009 Port: pp_hh  input  2H  a_hi*b_hi.
REQ-010 Port: out_valid  output  1  product valid.
REQ-011 Port: out_ready  input  1  consumer accepts the product.
REQ-012 Port: product  output  4H  full product.
REQ-013 Port: out_count  output  16  count of products accepted downstream.

Function
REQ-014 The block SHALL compute product = pp_ll + ((pp_lh + pp_hl) << H) + (pp_hh << 2H), exact, with no truncation in 4H bits.
REQ-015 Stage 1 SHALL register mid = pp_lh + pp_hl (2H+1 bits, carry kept), pp_ll, pp_hh and a valid bit v1.
REQ-016 Stage 2 SHALL register the final 4H-bit sum and a valid bit v2; out_valid = v2.
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-018 Latency SHALL be 2 cycles from input transfer to out_valid when out_ready is held high; throughput SHALL be 1 set per cycle.
REQ-019 Stage 2 SHALL load when !v2 || out_ready; stage 1 SHALL load when !v1 || stage 2 loads (bubbles collapse).
REQ-020 While out_valid is high and out_ready is low, product SHALL hold stable and no data SHALL be lost or duplicated.
REQ-021 Simultaneous output transfer and input transfer in the same cycle SHALL both complete.
REQ-022 out_count SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-023 Inputs SHALL be ignored (not captured) when in_valid is low.

Reset
REQ-024 While rst is high at a clk edge: v1, v2, out_valid, out_count SHALL be 0, product SHALL be 0, and in_ready SHALL be 0 during the rst cycle.
REQ-025 rst asserted mid-operation SHALL discard all in-flight sets; the first output after reset SHALL be from a set accepted after rst deasserts.

Configuration
REQ-026 Macro VEDIC_COMBINE_SKID_EN: when defined, a 1-entry skid buffer SHALL sit at the input so that in_ready is driven directly by a flop (no combinational path from out_ready); in_ready drops only when the skid entry is full; latency stays 2 cycles when the skid is empty, +1 when the skid is occupied.
REQ-027 Without VEDIC_COMBINE_SKID_EN: in_ready = !v1 || !v2 || out_ready (combinational), and there SHALL be no skid storage.
REQ-028 Both builds SHALL produce identical product sequences for identical accepted inputs.

Structure
REQ-029 Shared package vedic_pkg SHALL hold the H default, the derived widths (2H, 2H+1, 4H), and the out_count width constant 16.
REQ-030 One sub-module vedic_skid_buf (parameterised width, valid/ready on both sides) SHALL be instantiated only under VEDIC_COMBINE_SKID_EN.

Verification
REQ-031 With H=4, pp_ll=pp_lh=pp_hl=pp_hh=0xE1 (0xFF*0xFF) and out_ready=1 -> product=0xFE01 with out_valid exactly 2 cycles after the transfer.
REQ-032 pp_ll=0x08, pp_lh=0x06, pp_hl=0x04, pp_hh=0x03 (0x12*0x34) -> product=0x03A8.
REQ-033 Stream of 8 back-to-back sets with out_ready low for cycles 3-6 -> all 8 products emitted in order with no loss or duplication, and product stable while stalled.
REQ-034 Preload out_count to 0xFFFF via 65535 transfers, then 1 more transfer -> out_count=0x0000.
REQ-035 rst pulsed for 1 cycle with 2 sets in flight -> out_valid=0 the next cycle, and the next product corresponds to a post-reset input.
REQ-036 Run in both builds (VEDIC_COMBINE_SKID_EN defined and undefined) with random valid/ready traffic -> identical product sequences; with the macro defined, in_ready has no combinational dependence on out_ready.

Source files
------------

// File: rtl/vedic_pp_combine_pkg.sv
// Shared widths for the Vedic partial-product combiner (half-operand width H).
// Build option VEDIC_COMBINE_SKID_EN is consumed by vedic_pp_combine, not here.
package vedic_pkg;

  localparam int H_DEF = 4;
  localparam int CNT_W = 16;

  function automatic int pp_width(input int h);
    return 2 * h;
  endfunction

  function automatic int mid_width(input int h);
    return 2 * h + 1;
  endfunction

  function automatic int prod_width(input int h);
    return 4 * h;
  endfunction

  localparam int PP_W_DEF   = pp_width(H_DEF);
  localparam int MID_W_DEF  = mid_width(H_DEF);
  localparam int PROD_W_DEF = prod_width(H_DEF);

endpackage

// File: rtl/vedic_pp_combine_if.sv
// Partial-product input bus, product output bus and delivered-product counter.
interface vedic_pp_combine_if
  import vedic_pkg::*;
#(
  parameter int H = H_DEF
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [pp_width(H)-1:0]   pp_ll;
  logic [pp_width(H)-1:0]   pp_lh;
  logic [pp_width(H)-1:0]   pp_hl;
  logic [pp_width(H)-1:0]   pp_hh;
  logic                     out_valid;
  logic                     out_ready;
  logic [prod_width(H)-1:0] product;
  logic [CNT_W-1:0]         out_count;

  modport master (
    output in_valid, pp_ll, pp_lh, pp_hl, pp_hh, out_ready,
    input  in_ready, out_valid, product, out_count
  );

  modport slave (
    input  in_valid, pp_ll, pp_lh, pp_hl, pp_hh, out_ready,
    output in_ready, out_valid, product, out_count
  );

endinterface

// File: rtl/vedic_pp_combine_skid_buf.sv
// One-entry skid buffer; s_ready_o comes straight from a flop so the upstream
// side never sees a combinational path from m_ready_i.
module vedic_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         full_q, full_d;
  logic         ready_q;
  logic [W-1:0] buf_q, buf_d;
  logic         s_fire;

  always_comb begin
    full_d    = full_q;
    buf_d     = buf_q;
    s_fire    = s_valid_i && ready_q;
    m_valid_o = full_q || s_fire;
    m_data_o  = full_q ? buf_q : s_data_i;
    if (full_q) begin
      if (m_ready_i) full_d = 1'b0;
    end else if (s_fire && !m_ready_i) begin
      full_d = 1'b1;
      buf_d  = s_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign s_ready_o = ready_q;

endmodule

// File: rtl/vedic_pp_combine.sv
// Two-stage combiner: product = ll + ((lh + hl) << H) + (hh << 2H).
// Define VEDIC_COMBINE_SKID_EN to put a registered-ready skid buffer on the input.
module vedic_pp_combine
  import vedic_pkg::*;
#(
  parameter int H = H_DEF
) (
  input logic               clk,
  input logic               rst,
  vedic_pp_combine_if.slave bus
);

  localparam int PP_W   = pp_width(H);
  localparam int MID_W  = mid_width(H);
  localparam int PROD_W = prod_width(H);

  logic              pipe_valid;
  logic [PP_W-1:0]   pipe_ll, pipe_lh, pipe_hl, pipe_hh;
  logic              s1_load, s2_load, in_fire;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [MID_W-1:0]  mid_q, mid_d;
  logic [PP_W-1:0]   ll_q, ll_d, hh_q, hh_d;
  logic [PROD_W-1:0] product_q, product_d, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef VEDIC_COMBINE_SKID_EN
  logic [4*PP_W-1:0] sk_in, sk_out;

  assign sk_in = {bus.pp_ll, bus.pp_lh, bus.pp_hl, bus.pp_hh};

  vedic_skid_buf #(.W(4 * PP_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (bus.in_valid),
    .s_ready_o (bus.in_ready),
    .s_data_i  (sk_in),
    .m_valid_o (pipe_valid),
    .m_ready_i (s1_load),
    .m_data_o  (sk_out)
  );

  assign {pipe_ll, pipe_lh, pipe_hl, pipe_hh} = sk_out;
`else
  assign pipe_valid   = bus.in_valid;
  assign pipe_ll      = bus.pp_ll;
  assign pipe_lh      = bus.pp_lh;
  assign pipe_hl      = bus.pp_hl;
  assign pipe_hh      = bus.pp_hh;
  assign bus.in_ready = !rst && s1_load;
`endif

  // Stage 1 refills whenever stage 2 moves, so bubbles collapse in one cycle.
  assign s2_load = !v2_q || bus.out_ready;
  assign s1_load = !v1_q || s2_load;
  assign in_fire = pipe_valid && s1_load;

  assign sum = PROD_W'(ll_q) + (PROD_W'(mid_q) << H) + (PROD_W'(hh_q) << (2 * H));

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    v1_d      = v1_q;
    mid_d     = mid_q;
    ll_d      = ll_q;
    hh_d      = hh_q;
    v2_d      = v2_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    if (s1_load) begin
      v1_d = in_fire;
      if (in_fire) begin
        mid_d = MID_W'(pipe_lh) + MID_W'(pipe_hl);
        ll_d  = pipe_ll;
        hh_d  = pipe_hh;
      end
    end
    if (s2_load) begin
      v2_d = v1_q;
      if (v1_q) product_d = sum;
    end
    if (v2_q && bus.out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  // NOTE: stage-1 data is qualified by v1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    mid_q <= mid_d;
    ll_q  <= ll_d;
    hh_q  <= hh_d;
  end

  assign bus.out_valid = v2_q;
  assign bus.product   = product_q;
  assign bus.out_count = cnt_q;

endmodule
